// File: rtl/sha_status_pkg.sv
// Shared defaults and types for the SHA status tracker.
package sha_status_pkg;
    localparam int ID_WIDTH_DEF    = 6;
    localparam int DEPTH_DEF       = 4;
    localparam int COUNT_WIDTH_DEF = 10;

    typedef logic [ID_WIDTH_DEF-1:0] id_t;
    typedef logic [2:0]              occ_t;
endpackage

// File: rtl/sha_id_fifo.sv
// Small packet-ID FIFO with explicit occupancy; head read straight from storage.
module sha_id_fifo
    import sha_status_pkg::*;
#(
    parameter int ID_WIDTH = ID_WIDTH_DEF,
    parameter int DEPTH    = DEPTH_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_push,
    input  logic [ID_WIDTH-1:0] i_id,
    input  logic                i_pop,
    output logic [ID_WIDTH-1:0] o_head_id,
    output occ_t                o_occupancy,
    output logic                o_full,
    output logic                o_empty
);
    localparam logic [2:0] LAST_PTR  = 3'(DEPTH - 1);
    localparam occ_t       FULL_OCC  = 3'(DEPTH);

    logic [ID_WIDTH-1:0] mem_reg [DEPTH];
    logic [2:0]          wr_ptr_reg, rd_ptr_reg;
    occ_t                occ_reg;
    logic                push_ok, pop_ok;

    assign o_full      = (occ_reg == FULL_OCC);
    assign o_empty     = (occ_reg == 3'd0);
    assign push_ok     = i_push && !o_full;
    assign pop_ok      = i_pop && !o_empty;
    assign o_head_id   = mem_reg[rd_ptr_reg];
    assign o_occupancy = occ_reg;

    // Storage is reset so the head reads zero out of reset.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst)
                mem_reg[gi] <= '0;
            else if (push_ok && wr_ptr_reg == 3'(gi))
                mem_reg[gi] <= i_id;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? 3'd0 : wr_ptr_reg + 3'd1;
            if (pop_ok)
                rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? 3'd0 : rd_ptr_reg + 3'd1;
            if (push_ok && !pop_ok)
                occ_reg <= occ_reg + 3'd1;
            else if (pop_ok && !push_ok)
                occ_reg <= occ_reg - 3'd1;
        end
    end
endmodule

// File: rtl/sha_status_tracker.sv
// Status producer: ID FIFO, last-completed ID, sticky errors, wrapping packet counter.
// Optional sequence check of accepted IDs when SHA_STATUS_SEQ_CHECK_EN is defined.
module sha_status_tracker
    import sha_status_pkg::*;
#(
    parameter int ID_WIDTH    = ID_WIDTH_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_id_valid,
    input  logic [ID_WIDTH-1:0]    i_id,
    output logic                   o_id_ready,
    output logic                   o_head_valid,
    output logic [ID_WIDTH-1:0]    o_head_id,
    input  logic                   i_pkt_done,
    input  logic                   i_pkt_err,
    input  logic                   i_err_clear,
    output logic [ID_WIDTH-1:0]    o_status_id,
    output occ_t                   o_buffered_ids,
    output logic                   o_err_buffer,
    output logic                   o_err_packet,
    output logic [COUNT_WIDTH-1:0] o_packet_count
);
    logic                   full, empty, push_ok, pop_ok, underflow;
    logic                   clear_prev_reg, clear_edge, seq_err;
    logic [ID_WIDTH-1:0]    status_id_reg;
    logic [COUNT_WIDTH-1:0] count_reg;
    logic                   err_buffer_reg, err_packet_reg;

    // Ready depends only on registered occupancy, never on i_pkt_done.
    assign o_id_ready   = !full;
    assign o_head_valid = !empty;
    assign push_ok      = i_id_valid && !full;
    assign pop_ok       = i_pkt_done && !empty;
    assign underflow    = i_pkt_done && empty;
    assign clear_edge   = i_err_clear && !clear_prev_reg;

    sha_id_fifo #(.ID_WIDTH(ID_WIDTH), .DEPTH(DEPTH)) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (i_id_valid),
        .i_id        (i_id),
        .i_pop       (i_pkt_done),
        .o_head_id   (o_head_id),
        .o_occupancy (o_buffered_ids),
        .o_full      (full),
        .o_empty     (empty)
    );

`ifdef SHA_STATUS_SEQ_CHECK_EN
    logic [ID_WIDTH-1:0] last_id_reg, expect_id;
    logic                seen_reg;

    assign expect_id = last_id_reg + ID_WIDTH'(1);
    // The first accepted ID after reset has no predecessor to compare against.
    assign seq_err   = push_ok && seen_reg && (i_id != expect_id);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last_id_reg <= '0;
            seen_reg    <= 1'b0;
        end else if (push_ok) begin
            last_id_reg <= i_id;
            seen_reg    <= 1'b1;
        end
    end
`else
    assign seq_err = 1'b0;
`endif

    // Set events take priority over a same-cycle clear edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            status_id_reg  <= '0;
            count_reg      <= '0;
            err_buffer_reg <= 1'b0;
            err_packet_reg <= 1'b0;
            clear_prev_reg <= 1'b0;
        end else begin
            clear_prev_reg <= i_err_clear;
            if (pop_ok) begin
                status_id_reg <= o_head_id;
                count_reg     <= count_reg + COUNT_WIDTH'(1);
            end
            if (underflow)
                err_buffer_reg <= 1'b1;
            else if (clear_edge)
                err_buffer_reg <= 1'b0;
            if (i_pkt_err || seq_err)
                err_packet_reg <= 1'b1;
            else if (clear_edge)
                err_packet_reg <= 1'b0;
        end
    end

    assign o_status_id    = status_id_reg;
    assign o_packet_count = count_reg;
    assign o_err_buffer   = err_buffer_reg;
    assign o_err_packet   = err_packet_reg;
endmodule

// File: tb/tb_sha_status_tracker.sv
// Directed self-checking bench for sha_status_tracker (default parameters).
module tb_sha_status_tracker;
    import sha_status_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_ready, head_valid, pkt_done, pkt_err, err_clear;
    logic [5:0] id, head_id, status_id;
    occ_t       buffered_ids;
    logic       err_buffer, err_packet;
    logic [9:0] packet_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sha_status_tracker dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_id_valid     (id_valid),
        .i_id           (id),
        .o_id_ready     (id_ready),
        .o_head_valid   (head_valid),
        .o_head_id      (head_id),
        .i_pkt_done     (pkt_done),
        .i_pkt_err      (pkt_err),
        .i_err_clear    (err_clear),
        .o_status_id    (status_id),
        .o_buffered_ids (buffered_ids),
        .o_err_buffer   (err_buffer),
        .o_err_packet   (err_packet),
        .o_packet_count (packet_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
        $display("check %-14s observed=%0d expected=%0d", tag, obs, expv);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_sid"},   32'(status_id), 0);
        check({tag, "_cnt"},   32'(packet_count), 0);
        check({tag, "_occ"},   32'(buffered_ids), 0);
        check({tag, "_ebuf"},  32'(err_buffer), 0);
        check({tag, "_epkt"},  32'(err_packet), 0);
        check({tag, "_hv"},    32'(head_valid), 0);
        check({tag, "_hid"},   32'(head_id), 0);
        check({tag, "_rdy"},   32'(id_ready), 1);
    endtask

    initial begin
        rst = 1'b1; id_valid = 0; id = '0; pkt_done = 0; pkt_err = 0; err_clear = 0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check_reset_state("rst");

        // Fill with 5,6,7
        id_valid = 1; id = 6'd5; tick();
        id = 6'd6; tick();
        id = 6'd7; tick();
        id_valid = 0;
        check("fill3_occ", 32'(buffered_ids), 3);
        check("fill3_head", 32'(head_id), 5);
        check("fill3_rdy", 32'(id_ready), 1);
        check("fill3_hv", 32'(head_valid), 1);

        id_valid = 1; id = 6'd8; tick();
        check("full_occ", 32'(buffered_ids), 4);
        check("full_rdy", 32'(id_ready), 0);

        // Pop from full while offering an ID that must be refused
        id = 6'd9; pkt_done = 1; tick();
        id_valid = 0;
        check("popfull_sid", 32'(status_id), 5);
        check("popfull_cnt", 32'(packet_count), 1);
        check("popfull_occ", 32'(buffered_ids), 3);
        check("popfull_rdy", 32'(id_ready), 1);
        check("popfull_head", 32'(head_id), 6);

        tick(); tick(); tick();
        check("drain_sid", 32'(status_id), 8);
        check("drain_cnt", 32'(packet_count), 4);
        check("drain_occ", 32'(buffered_ids), 0);

        // Underflow
        tick();
        pkt_done = 0;
        check("uflow_ebuf", 32'(err_buffer), 1);
        check("uflow_cnt", 32'(packet_count), 4);
        check("uflow_sid", 32'(status_id), 8);
        check("uflow_occ", 32'(buffered_ids), 0);

        // Clear edge, held clear, re-arm
        err_clear = 1; tick();
        check("clr_edge", 32'(err_buffer), 0);
        pkt_done = 1; tick();
        pkt_done = 0;
        check("clr_held_set", 32'(err_buffer), 1);
        tick();
        check("clr_held_keep", 32'(err_buffer), 1);
        err_clear = 0; tick();
        err_clear = 1; tick();
        check("clr_rearm", 32'(err_buffer), 0);

        // Packet error coinciding with a clear edge
        err_clear = 0; tick();
        err_clear = 1; pkt_err = 1; tick();
        pkt_err = 0; err_clear = 0;
        check("set_wins", 32'(err_packet), 1);
        tick();

        // Counter wrap: count is 4, run 1019 push/pop pairs to 1023
        id_valid = 1; id = 6'd0; tick();
        pkt_done = 1;
        for (int i = 1; i <= 1019; i++) begin
            id = 6'(i);
            tick();
        end
        id_valid = 0;
        check("pre_wrap_cnt", 32'(packet_count), 1023);
        check("pre_wrap_occ", 32'(buffered_ids), 1);
        check("pre_wrap_sid", 32'(status_id), 58);
        check("pre_wrap_head", 32'(head_id), 59);
        tick();
        pkt_done = 0;
        check("wrap_cnt", 32'(packet_count), 0);
        check("wrap_sid", 32'(status_id), 59);
        check("wrap_occ", 32'(buffered_ids), 0);

        // Simultaneous push and pop at occupancy 2
        id_valid = 1; id = 6'd10; tick();
        id = 6'd11; tick();
        id = 6'd12; pkt_done = 1; tick();
        id_valid = 0;
        check("pp_occ", 32'(buffered_ids), 2);
        check("pp_sid", 32'(status_id), 10);
        check("pp_head", 32'(head_id), 11);
        check("pp_cnt", 32'(packet_count), 1);
        tick(); tick();
        pkt_done = 0;
        check("pp_drain_occ", 32'(buffered_ids), 0);
        check("pp_drain_sid", 32'(status_id), 12);

        // Clear both flags, then sequence gap 3 -> 5
        err_clear = 1; tick();
        err_clear = 0;
        check("clr2_epkt", 32'(err_packet), 0);
        check("clr2_ebuf", 32'(err_buffer), 0);
        id_valid = 1; id = 6'd3; tick();
        id = 6'd5; tick();
        id_valid = 0;
`ifdef SHA_STATUS_SEQ_CHECK_EN
        check("seq_gap", 32'(err_packet), 1);
`else
        check("seq_gap", 32'(err_packet), 0);
`endif
        check("seq_gap_occ", 32'(buffered_ids), 2);

        // 63 -> 0 is in sequence; clear edge on the 0 push leaves the flag low
        id_valid = 1; id = 6'd63; tick();
        id = 6'd0; err_clear = 1; tick();
        id_valid = 0; err_clear = 0;
        check("seq_wrap", 32'(err_packet), 0);
        check("seq_wrap_occ", 32'(buffered_ids), 4);
        check("seq_wrap_rdy", 32'(id_ready), 0);

        // Asynchronous reset mid-stream
        pkt_err = 1; tick();
        pkt_err = 0;
        check("pre_rst_epkt", 32'(err_packet), 1);
        check("pre_rst_head", 32'(head_id), 3);
        #2 rst = 1'b1;
        #1;
        check_reset_state("arst");
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_occ", 32'(buffered_ids), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
